// File: rtl/dccm_bank_arb.sv
// Two-master (LSU/DMA) front end for the banked DCCM: bank decode, same-bank
// arbitration with DMA priority plus LSU anti-starvation, 1-cycle read return.
module dccm_bank_arb #(
   parameter  int NUM_BANKS   = 2,
   parameter  int INDEX_DEPTH = 8192,
   parameter  int DATA_WIDTH  = 32,
   parameter  int STARVE_MAX  = 4,
   localparam int BANK_W      = $clog2(NUM_BANKS),
   localparam int IDX_W       = $clog2(INDEX_DEPTH),
   localparam int ADDR_W      = BANK_W + IDX_W
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            lsu_req_valid,
   output logic                            lsu_req_ready,
   input  logic                            lsu_req_we,
   input  logic [ADDR_W-1:0]               lsu_req_addr,
   input  logic [DATA_WIDTH-1:0]           lsu_req_wdata,
   input  logic                            dma_req_valid,
   output logic                            dma_req_ready,
   input  logic                            dma_req_we,
   input  logic [ADDR_W-1:0]               dma_req_addr,
   input  logic [DATA_WIDTH-1:0]           dma_req_wdata,
   output logic [NUM_BANKS-1:0]            bank_rden,
   output logic [NUM_BANKS-1:0]            bank_wren,
   output logic [NUM_BANKS*IDX_W-1:0]      bank_addr,
   output logic [NUM_BANKS*DATA_WIDTH-1:0] bank_wr_data,
   input  logic [NUM_BANKS*DATA_WIDTH-1:0] bank_rd_data,
   output logic                            lsu_rsp_valid,
   output logic [DATA_WIDTH-1:0]           lsu_rsp_data,
   output logic                            dma_rsp_valid,
   output logic [DATA_WIDTH-1:0]           dma_rsp_data
);

   logic [BANK_W-1:0] w_lsu_bank;
   logic [BANK_W-1:0] w_dma_bank;
   logic [IDX_W-1:0]  w_lsu_idx;
   logic [IDX_W-1:0]  w_dma_idx;
   logic              w_conflict;
   logic              w_lsu_force;
   logic              w_lsu_gnt;
   logic              w_dma_gnt;

   logic [3:0]        r_starve_cnt;
   logic              r_lsu_rsp_valid;
   logic              r_dma_rsp_valid;
   logic [BANK_W-1:0] r_lsu_rsp_bank;
   logic [BANK_W-1:0] r_dma_rsp_bank;

   assign w_lsu_bank = lsu_req_addr[BANK_W-1:0];
   assign w_dma_bank = dma_req_addr[BANK_W-1:0];
   assign w_lsu_idx  = lsu_req_addr[ADDR_W-1:BANK_W];
   assign w_dma_idx  = dma_req_addr[ADDR_W-1:BANK_W];

   assign w_conflict  = lsu_req_valid && dma_req_valid && (w_lsu_bank == w_dma_bank);
   assign w_lsu_force = (r_starve_cnt == 4'(STARVE_MAX));

   assign lsu_req_ready = !w_conflict || w_lsu_force;
   assign dma_req_ready = !w_conflict || !w_lsu_force;
   assign w_lsu_gnt     = lsu_req_valid && lsu_req_ready;
   assign w_dma_gnt     = dma_req_valid && dma_req_ready;

   // Counter only advances on a lost conflict, so it saturates at STARVE_MAX.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (w_lsu_gnt) begin
         r_starve_cnt <= '0;
      end else if (w_conflict) begin
         r_starve_cnt <= r_starve_cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_lsu_rsp_valid <= 1'b0;
         r_dma_rsp_valid <= 1'b0;
         r_lsu_rsp_bank  <= '0;
         r_dma_rsp_bank  <= '0;
      end else begin
         r_lsu_rsp_valid <= w_lsu_gnt && !lsu_req_we;
         r_dma_rsp_valid <= w_dma_gnt && !dma_req_we;
         if (w_lsu_gnt && !lsu_req_we) r_lsu_rsp_bank <= w_lsu_bank;
         if (w_dma_gnt && !dma_req_we) r_dma_rsp_bank <= w_dma_bank;
      end
   end

   // Both grants can never target the same bank, so the two ifs never overlap.
   always_comb begin
      bank_rden    = '0;
      bank_wren    = '0;
      bank_addr    = '0;
      bank_wr_data = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (w_lsu_gnt && (w_lsu_bank == BANK_W'(b))) begin
            bank_rden[b]                          = !lsu_req_we;
            bank_wren[b]                          = lsu_req_we;
            bank_addr[b*IDX_W +: IDX_W]           = w_lsu_idx;
            bank_wr_data[b*DATA_WIDTH +: DATA_WIDTH] = lsu_req_wdata;
         end
         if (w_dma_gnt && (w_dma_bank == BANK_W'(b))) begin
            bank_rden[b]                          = !dma_req_we;
            bank_wren[b]                          = dma_req_we;
            bank_addr[b*IDX_W +: IDX_W]           = w_dma_idx;
            bank_wr_data[b*DATA_WIDTH +: DATA_WIDTH] = dma_req_wdata;
         end
      end
   end

   always_comb begin
      lsu_rsp_data = '0;
      dma_rsp_data = '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
         if (r_lsu_rsp_valid && (r_lsu_rsp_bank == BANK_W'(b)))
            lsu_rsp_data = bank_rd_data[b*DATA_WIDTH +: DATA_WIDTH];
         if (r_dma_rsp_valid && (r_dma_rsp_bank == BANK_W'(b)))
            dma_rsp_data = bank_rd_data[b*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign lsu_rsp_valid = r_lsu_rsp_valid;
   assign dma_rsp_valid = r_dma_rsp_valid;

endmodule

// File: tb/tb_dccm_bank_arb.sv
// Directed bench for dccm_bank_arb: stimulus pushes expected read data into
// per-port queues, a negedge monitor pops and compares on rsp_valid.
module tb_dccm_bank_arb;
   localparam int NB = 2;
   localparam int ID = 8192;
   localparam int DW = 32;
   localparam int IW = 13;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          lsu_req_valid = 1'b0, lsu_req_we = 1'b0;
   logic [AW-1:0] lsu_req_addr = '0;
   logic [DW-1:0] lsu_req_wdata = '0;
   logic          dma_req_valid = 1'b0, dma_req_we = 1'b0;
   logic [AW-1:0] dma_req_addr = '0;
   logic [DW-1:0] dma_req_wdata = '0;
   logic          lsu_req_ready, dma_req_ready;
   logic [NB-1:0] bank_rden, bank_wren;
   logic [NB*IW-1:0] bank_addr;
   logic [NB*DW-1:0] bank_wr_data;
   logic [NB*DW-1:0] bank_rd_data = '0;
   logic          lsu_rsp_valid, dma_rsp_valid;
   logic [DW-1:0] lsu_rsp_data, dma_rsp_data;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] q_lsu[$];
   logic [DW-1:0] q_dma[$];
   logic [DW-1:0] mem [NB][ID];

   always #5 clk = ~clk;

   dccm_bank_arb #(.NUM_BANKS(NB), .INDEX_DEPTH(ID), .DATA_WIDTH(DW), .STARVE_MAX(4)) dut (
      .clk(clk), .rst(rst),
      .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_we(lsu_req_we),
      .lsu_req_addr(lsu_req_addr), .lsu_req_wdata(lsu_req_wdata),
      .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_we(dma_req_we),
      .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
      .bank_rden(bank_rden), .bank_wren(bank_wren), .bank_addr(bank_addr),
      .bank_wr_data(bank_wr_data), .bank_rd_data(bank_rd_data),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data),
      .dma_rsp_valid(dma_rsp_valid), .dma_rsp_data(dma_rsp_data)
   );

   // Single-port RAM model per bank, registered read.
   initial begin
      for (int b = 0; b < NB; b++)
         for (int i = 0; i < ID; i++) mem[b][i] = '0;
   end
   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (bank_wren[b]) mem[b][bank_addr[b*IW +: IW]] <= bank_wr_data[b*DW +: DW];
         if (bank_rden[b]) bank_rd_data[b*DW +: DW] <= mem[b][bank_addr[b*IW +: IW]];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (lsu_rsp_valid) begin
            if (q_lsu.size() == 0) begin
               checks++; errors++;
               $display("FAIL lsu_rsp_unexpected actual=%0d required=none t=%0t", lsu_rsp_data, $time);
            end else chk("lsu_rsp_data", 64'(lsu_rsp_data), 64'(q_lsu.pop_front()));
         end else chk("lsu_rsp_idle_data", 64'(lsu_rsp_data), 64'd0);
         if (dma_rsp_valid) begin
            if (q_dma.size() == 0) begin
               checks++; errors++;
               $display("FAIL dma_rsp_unexpected actual=%0d required=none t=%0t", dma_rsp_data, $time);
            end else chk("dma_rsp_data", 64'(dma_rsp_data), 64'(q_dma.pop_front()));
         end else chk("dma_rsp_idle_data", 64'(dma_rsp_data), 64'd0);
      end
   end

   task automatic next_cycle();
      @(posedge clk); #1;
   endtask

   task automatic set_lsu(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      lsu_req_valid = v; lsu_req_we = we; lsu_req_addr = a; lsu_req_wdata = d;
   endtask

   task automatic set_dma(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      dma_req_valid = v; dma_req_we = we; dma_req_addr = a; dma_req_wdata = d;
   endtask

   initial begin
      // Reset then idle
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("idle_rden", 64'(bank_rden), 64'd0);
      chk("idle_wren", 64'(bank_wren), 64'd0);
      chk("idle_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
      chk("idle_dma_rsp_valid", 64'(dma_rsp_valid), 64'd0);
      chk("idle_lsu_ready", 64'(lsu_req_ready), 64'd1);
      chk("idle_dma_ready", 64'(dma_req_ready), 64'd1);

      // Parallel writes to different banks, then parallel reads
      next_cycle();
      set_lsu(1, 1, 14'h0006, 32'd130);
      set_dma(1, 1, 14'h0007, 32'd231);
      @(negedge clk);
      chk("par_wr_lsu_ready", 64'(lsu_req_ready), 64'd1);
      chk("par_wr_dma_ready", 64'(dma_req_ready), 64'd1);
      chk("par_wr_wren", 64'(bank_wren), 64'd3);
      chk("par_wr_rden", 64'(bank_rden), 64'd0);
      chk("par_wr_addr", 64'(bank_addr), {38'd0, 13'd3, 13'd3});
      chk("par_wr_data", 64'(bank_wr_data), {32'd231, 32'd130});
      next_cycle();
      set_lsu(1, 0, 14'h0006, 32'd0);
      set_dma(1, 0, 14'h0007, 32'd0);
      q_lsu.push_back(32'd130);
      q_dma.push_back(32'd231);
      @(negedge clk);
      chk("par_rd_rden", 64'(bank_rden), 64'd3);
      chk("par_rd_addr", 64'(bank_addr), {38'd0, 13'd3, 13'd3});
      chk("par_rd_unsel_wdata", 64'(bank_wr_data), 64'd0);

      // Preload bank0 idx1 through DMA
      next_cycle();
      set_lsu(0, 0, '0, '0);
      set_dma(1, 1, 14'h0002, 32'd77);
      @(negedge clk);
      chk("preload_dma_ready", 64'(dma_req_ready), 64'd1);
      chk("preload_addr_b0", 64'(bank_addr[IW-1:0]), 64'd1);

      // Sustained bank0 conflict: DMA wins 4, LSU wins 1, period 5
      next_cycle();
      set_lsu(1, 0, 14'h0006, '0);
      set_dma(1, 0, 14'h0002, '0);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("conf_lsu_ready", 64'(lsu_req_ready), 64'((i % 5) == 4));
         chk("conf_dma_ready", 64'(dma_req_ready), 64'((i % 5) != 4));
         chk("conf_rden", 64'(bank_rden), 64'd1);
         if ((i % 5) == 4) q_lsu.push_back(32'd130);
         else              q_dma.push_back(32'd77);
         next_cycle();
      end

      // DMA write and LSU read of the same word: serialised, read sees write
      set_lsu(1, 0, 14'h0006, '0);
      set_dma(1, 1, 14'h0006, 32'd330);
      @(negedge clk);
      chk("wr_rd_dma_ready", 64'(dma_req_ready), 64'd1);
      chk("wr_rd_lsu_ready", 64'(lsu_req_ready), 64'd0);
      chk("wr_rd_wren", 64'(bank_wren), 64'd1);
      chk("wr_rd_rden", 64'(bank_rden), 64'd0);
      next_cycle();
      set_dma(0, 0, '0, '0);
      @(negedge clk);
      chk("wr_rd_lsu_ready2", 64'(lsu_req_ready), 64'd1);
      chk("wr_rd_rden2", 64'(bank_rden), 64'd1);
      q_lsu.push_back(32'd330);
      next_cycle();
      set_lsu(0, 0, '0, '0);

      // Reset mid-read: build starve count, accept reads, reset before the edge
      next_cycle();
      set_lsu(1, 0, 14'h0006, '0);
      set_dma(1, 0, 14'h0002, '0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("pre_rst_lsu_ready", 64'(lsu_req_ready), 64'd0);
         q_dma.push_back(32'd77);
         next_cycle();
      end
      set_lsu(1, 0, 14'h0007, '0);
      @(negedge clk);
      chk("rst_rd_lsu_ready", 64'(lsu_req_ready), 64'd1);
      chk("rst_rd_dma_ready", 64'(dma_req_ready), 64'd1);
      #2 rst = 1'b1;
      @(posedge clk); #1;
      set_lsu(0, 0, '0, '0);
      set_dma(0, 0, '0, '0);
      chk("rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
      chk("rst_dma_rsp_valid", 64'(dma_rsp_valid), 64'd0);
      #1 rst = 1'b0;
      chk("rst_starve_cnt", 64'(dut.r_starve_cnt), 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_lsu_rsp_valid", 64'(lsu_rsp_valid), 64'd0);
         chk("post_rst_dma_rsp_valid", 64'(dma_rsp_valid), 64'd0);
      end

      // Streaming: 8 writes then 8 back-to-back reads over alternating banks
      for (int i = 0; i < 8; i++) begin
         next_cycle();
         set_lsu(1, 1, AW'(14'h0020 + i), DW'(1000 + i));
         @(negedge clk);
         chk("strm_wr_ready", 64'(lsu_req_ready), 64'd1);
         chk("strm_wr_wren", 64'(bank_wren), (i % 2 == 0) ? 64'd1 : 64'd2);
      end
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         if (i < 8) begin
            set_lsu(1, 0, AW'(14'h0020 + i), '0);
            q_lsu.push_back(DW'(1000 + i));
         end else set_lsu(0, 0, '0, '0);
         @(negedge clk);
         chk("strm_rsp_valid", 64'(lsu_rsp_valid), 64'((i >= 1) && (i <= 8)));
      end

      repeat (3) next_cycle();
      chk("lsu_queue_drained", 64'(q_lsu.size()), 64'd0);
      chk("dma_queue_drained", 64'(q_dma.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/dccm_bank_arb.md
Name: dccm_bank_arb

Overview:
- Request front end that sits directly upstream of the DCCM bank array (NUM_BANKS single-port RAMs, each INDEX_DEPTH x DATA_WIDTH).
- Accepts word requests from two masters, LSU and DMA, each with valid/ready.
- Decodes bank and index from the address and drives per-bank read/write strobes.
- Resolves same-bank conflicts with a DMA-priority policy plus an LSU anti-starvation counter, and returns read data one cycle after acceptance.

Parameters:
NUM_BANKS, 2, number of RAM banks; power of two, >= 2
INDEX_DEPTH, 8192, words per bank; power of two
DATA_WIDTH, 32, word width in bits
STARVE_MAX, 4, consecutive lost LSU conflicts before LSU is forced to win; range 1..15
(local) BANK_W = log2(NUM_BANKS), IDX_W = log2(INDEX_DEPTH), ADDR_W = BANK_W + IDX_W

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
lsu_req_valid  in  1  LSU request present
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_we  in  1  1 = write, 0 = read
lsu_req_addr  in  ADDR_W  word address; bank = addr[BANK_W-1:0], index = addr[ADDR_W-1:BANK_W]
lsu_req_wdata  in  DATA_WIDTH  write data
dma_req_valid / dma_req_ready / dma_req_we / dma_req_addr / dma_req_wdata  same widths and meaning as the LSU set
bank_rden  out  NUM_BANKS  per-bank read strobe
bank_wren  out  NUM_BANKS  per-bank write strobe
bank_addr  out  NUM_BANKS*IDX_W  per-bank index; bank b occupies slice [b*IDX_W +: IDX_W]
bank_wr_data  out  NUM_BANKS*DATA_WIDTH  per-bank write data
bank_rd_data  in  NUM_BANKS*DATA_WIDTH  per-bank RAM output; valid the cycle after bank_rden
lsu_rsp_valid  out  1  LSU read data valid
lsu_rsp_data  out  DATA_WIDTH  LSU read data
dma_rsp_valid  out  1  DMA read data valid
dma_rsp_data  out  DATA_WIDTH  DMA read data

Behaviour:
- Reset state: starve_cnt = 0, both rsp_valid = 0, registered response bank selects = 0.
- Reset output values: rsp_data = 0; bank_rden/bank_wren = 0 while valids are low.
- Reset asserted mid-operation drops any pending read response; no rsp_valid appears after reset release.
- Conflict definition: both valids are high and their bank fields are equal.
- No conflict: each valid request is granted. A request is granted when valid && ready; ready is 1 when the port is idle.
- Conflict, starve_cnt < STARVE_MAX: DMA is granted; lsu_req_ready = 0; starve_cnt increments.
- Conflict, starve_cnt == STARVE_MAX: LSU is granted; dma_req_ready = 0.
- starve_cnt resets to 0 on any LSU grant and holds otherwise.
- Ready is combinational from the current-cycle valids and addresses. Masters must hold request fields stable while valid && !ready.
- Grant to bank b: bank_rden[b] = !we, bank_wren[b] = we, and bank_addr/bank_wr_data slice b driven from the granted port, all in the same cycle.
- Unselected bank slices: addr/data driven to 0.
- Two grants to different banks in one cycle are both issued. Read/read, read/write and write/write combinations are all legal.
- Read latency is exactly 1 cycle. A read accepted in cycle N gives rsp_valid = 1 in cycle N+1, with rsp_data = bank_rd_data slice of the bank registered at N.
- Writes produce no response.
- Response paths have no backpressure.
- Back-to-back reads on one port give rsp_valid on consecutive cycles.
- rsp_data = 0 whenever rsp_valid = 0.
- Write and read to the same bank from different ports is a conflict and is serialised. The later read observes the earlier write (the RAM is write-first on a later cycle).

Test Plan:
- Reset then idle: rst pulse with all valids low -> all strobes 0, rsp_valid 0, both readies 1.
- Parallel write/read, NUM_BANKS=2: LSU write addr 0x0006 (bank0, idx3) data 130 and DMA write addr 0x0007 (bank1, idx3) data 231 in one cycle -> both readies 1, bank_wren=2'b11. Then both read the same addresses -> next cycle lsu_rsp_data=130, dma_rsp_data=231.
- Conflict: both ports read bank0 continuously -> DMA granted 4 cycles with lsu_req_ready=0, LSU granted on cycle 5, DMA granted cycle 6, and the pattern repeats with a 5-cycle period.
- Write then read, same bank, two ports: DMA write idx3=330 and LSU read idx3 in the same cycle -> DMA granted first. The LSU read is granted next cycle and returns 330 one cycle later.
- Reset mid-read: LSU read accepted in cycle N, rst asserted asynchronously before edge N+1 -> lsu_rsp_valid stays 0 and starve_cnt reads 0 after release.
- Streaming: 8 back-to-back LSU reads of alternating banks with DMA idle -> 8 consecutive lsu_rsp_valid cycles with matching data order.
